// File: rtl/key_conditioner_pkg.sv
// Shared types for the key conditioner: key FSM state encoding, mode codes, counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package key_conditioner_pkg;

    // Key debounce FSM states; REPEAT only reachable when KEY_AUTO_REPEAT_EN is defined
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } key_st_e;

    // Mode switch codes as seen on key_state
    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_NIGHT  = 2'b01;
    localparam logic [1:0] MODE_SET_RG = 2'b10;
    localparam logic [1:0] MODE_SET_Y  = 2'b11;

    // Width of a tick counter that must hold the largest of the given terminal counts
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

    // PLUS/SUB only act in the two set modes (upper mode bit set)
    function automatic logic is_set_mode(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/key_conditioner_fsm.sv
// Per-key debounce FSM: accepts a press after DEBOUNCE_TICKS stable ticks and emits one pulse (plus repeats with KEY_AUTO_REPEAT_EN).
// Latency: pulse registered on the clk that the DEBOUNCE_TICKS-th stable tick is seen in DEB_PRESS.
// Backpressure: none; pulses are fire-and-forget.
module key_debounce_fsm
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
`ifdef KEY_AUTO_REPEAT_EN
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100,
`endif
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic key_pressed,
    input  logic tick,
    output logic pulse
);

    // Terminal values are checked one tick early so the count lands exactly on the target
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    key_st_e          state;
    logic [CNT_W-1:0] cnt;

    // Press/release debounce state machine with registered single-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_pressed) begin
                        state <= DEB_PRESS;
                        cnt   <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!key_pressed) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (cnt >= DEB_LAST) begin
                            state <= HELD;
                            cnt   <= '0;
                            pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!key_pressed) begin
                        state <= DEB_RELEASE;
                        cnt   <= '0;
                    end
`ifdef KEY_AUTO_REPEAT_EN
                    else if (tick) begin
                        if (cnt >= DLY_LAST) begin
                            state <= REPEAT;
                            cnt   <= '0;
                            pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`else
                    // A held key just waits for release: one pulse per accepted press
`endif
                end
`ifdef KEY_AUTO_REPEAT_EN
                REPEAT: begin
                    if (!key_pressed) begin
                        state <= DEB_RELEASE;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt >= PER_LAST) begin
                            cnt   <= '0;
                            pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`endif
                DEB_RELEASE: begin
                    // A bounce back to pressed resumes the hold without a new pulse
                    if (key_pressed) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt >= DEB_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Board-pin front end: synchronises and debounces the mode switch and PLUS/SUB keys (optional KEY_AUTO_REPEAT_EN).
// Latency: 2 clk synchroniser + DEBOUNCE_TICKS ticks (+ up to 1 tick of divider phase) to a level change or press pulse.
// Backpressure: none; pulses are single-cycle and must be consumed on the cycle they appear.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int CLK_HZ         = 12_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_state_raw,
    input  logic       key_plus_raw,
    input  logic       key_sub_raw,
    output logic [1:0] key_state,
    output logic       key_state_chg,
    output logic       key_plus_pulse,
    output logic       key_sub_pulse
);

    // One counter width serves every tick count in the block
    localparam int CNT_W = cnt_width(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_PERIOD);

    localparam int                 DIV      = CLK_HZ / TICK_HZ;
    localparam int                 DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0]   DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic               KEY_IDLE = KEY_ACTIVE_LOW;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       mode_s1, mode_s2;
    logic             plus_s1, plus_s2, sub_s1, sub_s2;
    logic             plus_pressed, sub_pressed;
    logic [1:0]       mode_cand;
    logic [CNT_W-1:0] mode_cnt;
    logic             plus_fsm_pulse, sub_fsm_pulse;
    logic             conflict, set_mode;

    // Debounce time base: 1-clk tick at the divider's terminal count
    assign tick = (div_cnt == DIV_LAST);

    // Free-running tick divider, wraps to 0 after the terminal count
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Two-flop synchronisers; reset to the inactive level so nothing looks pressed out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1 <= MODE_NIGHT;
            mode_s2 <= MODE_NIGHT;
            plus_s1 <= KEY_IDLE;
            plus_s2 <= KEY_IDLE;
            sub_s1  <= KEY_IDLE;
            sub_s2  <= KEY_IDLE;
        end else begin
            mode_s1 <= key_state_raw;
            mode_s2 <= mode_s1;
            plus_s1 <= key_plus_raw;
            plus_s2 <= plus_s1;
            sub_s1  <= key_sub_raw;
            sub_s2  <= sub_s1;
        end
    end

    // Pressed means "differs from the idle pin level", whichever polarity the board uses
    assign plus_pressed = plus_s2 ^ KEY_IDLE;
    assign sub_pressed  = sub_s2 ^ KEY_IDLE;

    // Mode vector debounce: any candidate change restarts the count; accept after DEBOUNCE_TICKS stable ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_cand     <= MODE_NIGHT;
            mode_cnt      <= '0;
            key_state     <= MODE_NIGHT;
            key_state_chg <= 1'b0;
        end else begin
            key_state_chg <= 1'b0;
            if (mode_s2 != mode_cand) begin
                mode_cand <= mode_s2;
                mode_cnt  <= '0;
            end else if (mode_cand == key_state) begin
                mode_cnt <= '0;
            end else if (tick) begin
                if (mode_cnt >= DEB_LAST) begin
                    key_state     <= mode_cand;
                    key_state_chg <= 1'b1;
                    mode_cnt      <= '0;
                end else begin
                    mode_cnt <= mode_cnt + 1'b1;
                end
            end
        end
    end

    key_debounce_fsm #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
`ifdef KEY_AUTO_REPEAT_EN
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
        .CNT_W          (CNT_W)
    ) u_plus_fsm (
        .clk         (clk),
        .rst         (rst),
        .key_pressed (plus_pressed),
        .tick        (tick),
        .pulse       (plus_fsm_pulse)
    );

    key_debounce_fsm #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
`ifdef KEY_AUTO_REPEAT_EN
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
        .CNT_W          (CNT_W)
    ) u_sub_fsm (
        .clk         (clk),
        .rst         (rst),
        .key_pressed (sub_pressed),
        .tick        (tick),
        .pulse       (sub_fsm_pulse)
    );

    // Ambiguous PLUS+SUB on the same clk is dropped; keys are ignored outside the set modes.
    // All inputs here are flops, so the outputs are clean single-cycle pulses.
    assign conflict       = plus_fsm_pulse & sub_fsm_pulse;
    assign set_mode       = is_set_mode(key_state);
    assign key_plus_pulse = plus_fsm_pulse & ~conflict & set_mode;
    assign key_sub_pulse  = sub_fsm_pulse & ~conflict & set_mode;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random pin activity against a run-length model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_key_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_state_raw = 2'b01;
    logic       key_plus_raw = 1'b1;
    logic       key_sub_raw  = 1'b1;
    logic [1:0] key_state;
    logic       key_state_chg, key_plus_pulse, key_sub_pulse;

    key_conditioner #(
        .CLK_HZ         (1000),
        .TICK_HZ        (1000),
        .DEBOUNCE_TICKS (DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_state_raw  (key_state_raw),
        .key_plus_raw   (key_plus_raw),
        .key_sub_raw    (key_sub_raw),
        .key_state      (key_state),
        .key_state_chg  (key_state_chg),
        .key_plus_pulse (key_plus_pulse),
        .key_sub_pulse  (key_sub_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_plus, n_sub, n_chg, first_plus, first_sub;

    // Reference model: a level is accepted once its synchronised value has been seen on
    // DEB+1 consecutive clocks (entry clock plus DEB ticks); presses pulse on acceptance.
    logic [1:0] m_r1, m_r2, m_last, m_ks;
    int         m_run;
    bit         k_r1 [2];
    bit         k_r2 [2];
    bit         k_last [2];
    bit         k_lvl [2];
    int         k_run [2];
    int         k_held [2];
    bit         fire [2];
    logic [1:0] exp_ks;
    logic       exp_chg, exp_plus, exp_sub;

    task automatic model_reset();
        m_r1 = 2'b01; m_r2 = 2'b01; m_last = 2'b01; m_ks = 2'b01; m_run = 1;
        for (int i = 0; i < 2; i++) begin
            k_r1[i] = 1'b0; k_r2[i] = 1'b0; k_last[i] = 1'b0; k_lvl[i] = 1'b0;
            k_run[i] = 1; k_held[i] = 0; fire[i] = 1'b0;
        end
        exp_ks = 2'b01; exp_chg = 1'b0; exp_plus = 1'b0; exp_sub = 1'b0;
    endtask

    task automatic model_edge();
        bit p;
        if (rst) begin
            model_reset();
        end else begin
            if (m_r2 == m_last) m_run++;
            else begin m_last = m_r2; m_run = 1; end
            exp_chg = 1'b0;
            if (m_last != m_ks && m_run == DEB + 1) begin
                m_ks = m_last;
                exp_chg = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                p = k_r2[i];
                if (p == k_last[i]) k_run[i]++;
                else begin k_last[i] = p; k_run[i] = 1; end
                fire[i] = 1'b0;
                if (!k_lvl[i]) begin
                    if (p && k_run[i] == DEB + 1) begin
                        k_lvl[i] = 1'b1; fire[i] = 1'b1; k_held[i] = 0;
                    end
                end else if (!p) begin
                    if (k_run[i] == DEB + 1) k_lvl[i] = 1'b0;
                end else begin
                    if (k_run[i] == 1) k_held[i] = 0;
                    else k_held[i]++;
`ifdef KEY_AUTO_REPEAT_EN
                    if (k_run[i] > 1 && (k_held[i] == RD || (k_held[i] > RD && (k_held[i] - RD) % RP == 0)))
                        fire[i] = 1'b1;
`endif
                end
            end
            exp_ks   = m_ks;
            exp_plus = fire[0] && !fire[1] && m_ks[1];
            exp_sub  = fire[1] && !fire[0] && m_ks[1];
            m_r2 = m_r1; m_r1 = key_state_raw;
            k_r2[0] = k_r1[0]; k_r1[0] = ~key_plus_raw;
            k_r2[1] = k_r1[1]; k_r1[1] = ~key_sub_raw;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("key_state", 32'(key_state), 32'(exp_ks));
        check("key_state_chg", 32'(key_state_chg), 32'(exp_chg));
        check("key_plus_pulse", 32'(key_plus_pulse), 32'(exp_plus));
        check("key_sub_pulse", 32'(key_sub_pulse), 32'(exp_sub));
        if (key_plus_pulse) begin n_plus++; if (first_plus < 0) first_plus = cyc; end
        if (key_sub_pulse)  begin n_sub++;  if (first_sub < 0)  first_sub  = cyc; end
        if (key_state_chg)  n_chg++;
    endtask

    task automatic clear_counts();
        n_plus = 0; n_sub = 0; n_chg = 0; first_plus = -1; first_sub = -1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int edge_cyc;
        model_reset();
        clear_counts();

        // Reset: night mode, no pulses
        steps(3);
        check("reset_key_state", 32'(key_state), 32'h1);
        check("reset_pulses", 32'({key_state_chg, key_plus_pulse, key_sub_pulse}), 32'h0);

        // Idle pins for 50 clk: nothing happens
        rst = 1'b0;
        clear_counts();
        steps(50);
        check("idle_pulses", 32'(n_plus + n_sub + n_chg), 32'd0);

        // Mode 10, then a clean 10-clk PLUS press: one pulse, 2 sync + 4 ticks after the sampling edge
        key_state_raw = 2'b10;
        clear_counts();
        steps(10);
        check("set_rg_chg_count", 32'(n_chg), 32'd1);
        check("set_rg_state", 32'(key_state), 32'h2);
        clear_counts();
        key_plus_raw = 1'b0;
        edge_cyc = cyc + 1;
        steps(10);
        key_plus_raw = 1'b1;
        steps(10);
        check("plus_count", 32'(n_plus), 32'd1);
        check("plus_latency", 32'(first_plus - edge_cyc), 32'd6);

        // SUB bounces every 2 clk for 20 clk, then settles pressed
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            key_sub_raw = i[0];
            steps(2);
        end
        check("bounce_no_pulse", 32'(n_sub), 32'd0);
        key_sub_raw = 1'b0;
        edge_cyc = cyc + 1;
        steps(15);
        check("sub_count", 32'(n_sub), 32'd1);
        check("sub_latency", 32'(first_sub - edge_cyc), 32'd6);
        key_sub_raw = 1'b1;
        steps(10);

        // Mode 11: PLUS and SUB on the same clk cancel each other
        key_state_raw = 2'b11;
        steps(10);
        clear_counts();
        key_plus_raw = 1'b0; key_sub_raw = 1'b0;
        steps(10);
        key_plus_raw = 1'b1; key_sub_raw = 1'b1;
        steps(10);
        check("conflict_pulses", 32'(n_plus + n_sub), 32'd0);

        // Mode 00: PLUS is ignored and the mode stays put
        key_state_raw = 2'b00;
        steps(10);
        clear_counts();
        key_plus_raw = 1'b0;
        steps(10);
        key_plus_raw = 1'b1;
        steps(10);
        check("run_mode_plus", 32'(n_plus), 32'd0);
        check("run_mode_state", 32'(key_state), 32'h0);

        // Long PLUS hold in mode 10, then reset mid-hold
        key_state_raw = 2'b10;
        steps(10);
        clear_counts();
        key_plus_raw = 1'b0;
        steps(30);
`ifdef KEY_AUTO_REPEAT_EN
        check("hold_pulse_count", 32'(n_plus), 32'd7);
`else
        check("hold_pulse_count", 32'(n_plus), 32'd1);
`endif
        clear_counts();
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(5);
        check("rst_mid_hold", 32'(n_plus), 32'd0);
        check("rst_mid_hold_state", 32'(key_state), 32'h1);
        key_plus_raw = 1'b1;
        steps(20);

        // Random pin activity with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) key_state_raw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 8) key_plus_raw = ~key_plus_raw;
            if ($urandom_range(0, 99) < 8) key_sub_raw = ~key_sub_raw;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
